fpu_wb_arbiter: RTL
===================

FPU_WB_ARBITER -- requirements
Module: fpu_wb_arbiter

Interface
REQ-001 Parameter NREG, default 32, meaning number of float registers tracked (index width 5).
REQ-002 Ports: clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 issue_valid  in  1  issue stage marks a destination pending.
REQ-005 issue_rd  in  5  destination register being issued.
REQ-006 issue_ready  out  1  issue accepted this cycle.
REQ-007 s0_valid / s0_rd / s0_data  in  1/5/32  result from pipelined unit (fadd/fmul).
REQ-008 s0_ready  out  1  s0 result granted this cycle.
REQ-009 s1_valid / s1_rd / s1_data  in  1/5/32  result from iterative unit (fdiv/fsqrt).
REQ-010 s1_ready  out  1  s1 result granted this cycle.
REQ-011 rdi / write_data / reg_write  out  5/32/1  registered write port to the float register file.
REQ-012 q1_rs / q2_rs  in  5/5  hazard-query register indices.
REQ-013 q1_busy / q2_busy  out  1/1  combinational: queried register has a pending write.

Function
REQ-014 Scoreboard: NREG busy bits; bit set by an accepted issue, cleared by a granted result.
REQ-015 issue_ready = !busy[issue_rd], combinational; issue accepted when issue_valid && issue_ready.
REQ-016 Grant: at most one source per cycle; a grant is a source with valid=1 and ready=1.
REQ-017 Arbitration round-robin on a 1-bit last_grant register: if both valid, grant the source not granted last; if one valid, grant it.
REQ-018 last_grant updates only on a cycle with a grant.
REQ-019 Write latency 1: granted rd/data appear on rdi/write_data with reg_write=1 at the next edge; reg_write=0 in cycles after no grant.
REQ-020 rdi/write_data hold last values when reg_write=0.
REQ-021 Busy bit of granted rd clears at the same edge that raises reg_write; the register file's write bypass covers the following read.
REQ-022 Simultaneous accepted issue and grant to the same rd: set wins, busy stays 1.
REQ-023 q*_busy = busy[q*_rs] from registered state; no forwarding from same-cycle grant or issue.
REQ-024 A source whose valid is low is never granted; valid, rd and data are held by the source until ready.
REQ-025 Grant to a register whose busy bit is 0 is a protocol error; the block writes normally and leaves busy at 0.
REQ-026 s1 starvation bound: with s0 continuously valid, s1 is granted within 2 cycles of asserting valid.

Reset
REQ-027 On rst=1, immediately and independent of clk: all busy bits 0, last_grant=1 (s0 preferred first), reg_write=0, rdi=0, write_data=0.
REQ-028 Results and issues presented during reset are discarded; ready outputs are 0 while rst=1.
REQ-029 Reset mid-operation drops pending writes; sources re-present after reset deassertion.

Structure
REQ-030 Shared FPU package holds: register index width (5), data width (32), NREG, source-id encoding (S0=0, S1=1).
REQ-031 One sub-module: fpu_rr_arb2 (2-way round-robin arbiter with last_grant state); scoreboard and write register stay in the top.
REQ-032 No combinational path from s*_data to any output.

Verification
REQ-033 Reset, then issue rd=3; next cycle q1_rs=3 -> q1_busy=1, issue_ready=0 for rd=3.
REQ-034 s0 result rd=3 data=0x3F800000 -> s0_ready=1; next cycle reg_write=1, rdi=3, write_data=0x3F800000, busy[3]=0.
REQ-035 s0 and s1 valid together for 4 cycles (rd=1,2,...) -> grants alternate s0,s1,s0,s1; one reg_write per cycle.
REQ-036 Same-cycle issue rd=7 and grant of rd=7 (busy bit set beforehand) -> busy[7]=1 after edge.
REQ-037 Assert rst between grant and write-port update -> reg_write=0, all busy=0 immediately, no write emitted.
REQ-038 s0 valid every cycle, s1 raises valid at cycle 10 -> s1_ready=1 by cycle 11.

Source files
------------

// File: rtl/fpu_wb_arbiter_pkg.sv
// rtl/fpu_wb_arbiter_pkg.sv - shared FPU widths and result-source encoding
package fpu_wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int FPU_NREG  = 32;

  typedef enum logic {
    SRC_S0 = 1'b0,
    SRC_S1 = 1'b1
  } src_id_e;

endpackage

// File: rtl/fpu_wb_arbiter_if.sv
// rtl/fpu_wb_arbiter_if.sv - issue, result, write-port and hazard-query bundle
interface fpu_wb_if;
  import fpu_wb_arbiter_pkg::*;

  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 issue_ready;
  logic                 s0_valid;
  logic [REG_IDX_W-1:0] s0_rd;
  logic [DATA_W-1:0]    s0_data;
  logic                 s0_ready;
  logic                 s1_valid;
  logic [REG_IDX_W-1:0] s1_rd;
  logic [DATA_W-1:0]    s1_data;
  logic                 s1_ready;
  logic [REG_IDX_W-1:0] rdi;
  logic [DATA_W-1:0]    write_data;
  logic                 reg_write;
  logic [REG_IDX_W-1:0] q1_rs;
  logic [REG_IDX_W-1:0] q2_rs;
  logic                 q1_busy;
  logic                 q2_busy;

  modport master (
    output issue_valid, issue_rd, s0_valid, s0_rd, s0_data,
           s1_valid, s1_rd, s1_data, q1_rs, q2_rs,
    input  issue_ready, s0_ready, s1_ready, rdi, write_data, reg_write,
           q1_busy, q2_busy
  );

  modport slave (
    input  issue_valid, issue_rd, s0_valid, s0_rd, s0_data,
           s1_valid, s1_rd, s1_data, q1_rs, q2_rs,
    output issue_ready, s0_ready, s1_ready, rdi, write_data, reg_write,
           q1_busy, q2_busy
  );

endinterface

// File: rtl/fpu_rr_arb2.sv
// rtl/fpu_rr_arb2.sv - two-way round-robin arbiter with one-bit last-grant state
module fpu_rr_arb2
  import fpu_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  src_id_e r_last_grant;
  logic    w_pick_s1;

  // s1 wins only when alone or when s0 took the previous grant
  always_comb begin
    w_pick_s1 = i_req[SRC_S1] && (!i_req[SRC_S0] || (r_last_grant == SRC_S0));
    o_gnt     = 2'b00;
    if (!rst) begin
      o_gnt[SRC_S1] = w_pick_s1;
      o_gnt[SRC_S0] = i_req[SRC_S0] && !w_pick_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= SRC_S1;
    end else if (|o_gnt) begin
      r_last_grant <= o_gnt[SRC_S1] ? SRC_S1 : SRC_S0;
    end
  end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// rtl/fpu_wb_arbiter.sv - float register scoreboard and write-back arbitration
module fpu_wb_arbiter
  import fpu_wb_arbiter_pkg::*;
#(
  parameter int NREG = FPU_NREG
) (
  input  logic     clk,
  input  logic     rst,
  fpu_wb_if.slave  bus
);

  logic [NREG-1:0]      r_busy;
  logic                 r_reg_write;
  logic [REG_IDX_W-1:0] r_rdi;
  logic [DATA_W-1:0]    r_write_data;

  logic [1:0]           w_gnt;
  logic                 w_any_gnt;
  logic                 w_issue_acc;
  logic [REG_IDX_W-1:0] w_gnt_rd;
  logic [DATA_W-1:0]    w_gnt_data;
  logic [NREG-1:0]      w_busy_nxt;

  fpu_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({bus.s1_valid, bus.s0_valid}),
    .o_gnt (w_gnt)
  );

  assign w_any_gnt   = |w_gnt;
  assign w_gnt_rd    = w_gnt[SRC_S1] ? bus.s1_rd   : bus.s0_rd;
  assign w_gnt_data  = w_gnt[SRC_S1] ? bus.s1_data : bus.s0_data;

  assign bus.issue_ready = !rst && !r_busy[bus.issue_rd];
  assign w_issue_acc     = bus.issue_valid && bus.issue_ready;
  assign bus.s0_ready    = w_gnt[SRC_S0];
  assign bus.s1_ready    = w_gnt[SRC_S1];

  // Clear before set so a same-cycle issue to the granted rd keeps it busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_any_gnt) begin
      w_busy_nxt[w_gnt_rd] = 1'b0;
    end
    if (w_issue_acc) begin
      w_busy_nxt[bus.issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_reg_write  <= 1'b0;
      r_rdi        <= '0;
      r_write_data <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_reg_write <= w_any_gnt;
      if (w_any_gnt) begin
        r_rdi        <= w_gnt_rd;
        r_write_data <= w_gnt_data;
      end
    end
  end

  assign bus.rdi        = r_rdi;
  assign bus.write_data = r_write_data;
  assign bus.reg_write  = r_reg_write;
  assign bus.q1_busy    = r_busy[bus.q1_rs];
  assign bus.q2_busy    = r_busy[bus.q2_rs];

endmodule
